// File: rtl/video_timing_gen.sv
// Raster timing generator: signed scan positions plus hsync/vsync/data-enable/frame/line strobes; strobes lag positions by p_sync_delay.
// New modes are taken through valid/ready, held as pending (ready low) and swapped in on the last pixel of a frame.
module video_timing_gen #(
  parameter int p_count_width = 16,
  parameter int p_sync_delay  = 1,
  parameter int p_def_width   = 640,
  parameter int p_def_height  = 480,
  parameter int p_def_hfp     = 16,
  parameter int p_def_hpulse  = 96,
  parameter int p_def_hbp     = 48,
  parameter int p_def_vfp     = 10,
  parameter int p_def_vpulse  = 2,
  parameter int p_def_vbp     = 33,
  parameter bit p_def_hpol    = 1'b1,
  parameter bit p_def_vpol    = 1'b1
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_rst,
  input  logic                            i_cfg_valid,
  output logic                            o_cfg_ready,
  input  logic [p_count_width-1:0]        i_cfg_width,
  input  logic [p_count_width-1:0]        i_cfg_height,
  input  logic [p_count_width-1:0]        i_cfg_hfp,
  input  logic [p_count_width-1:0]        i_cfg_hpulse,
  input  logic [p_count_width-1:0]        i_cfg_hbp,
  input  logic [p_count_width-1:0]        i_cfg_vfp,
  input  logic [p_count_width-1:0]        i_cfg_vpulse,
  input  logic [p_count_width-1:0]        i_cfg_vbp,
  input  logic                            i_cfg_hpol,
  input  logic                            i_cfg_vpol,
  output logic                            o_cfg_applied,
  output logic                            o_cfg_err,
  output logic                            o_hsync,
  output logic                            o_vsync,
  output logic                            o_data_en,
  output logic                            o_frame,
  output logic                            o_line,
  output logic signed [p_count_width-1:0] o_x_pos,
  output logic signed [p_count_width-1:0] o_y_pos
);
  localparam int cw = p_count_width;
  typedef logic [cw-1:0] cnt_t;

  typedef struct packed {
    cnt_t width, height, hfp, hpulse, hbp, vfp, vpulse, vbp;
    logic hpol, vpol;
  } timing_cfg_t;

  localparam timing_cfg_t def_cfg = '{
    width: cnt_t'(p_def_width), height: cnt_t'(p_def_height),
    hfp: cnt_t'(p_def_hfp), hpulse: cnt_t'(p_def_hpulse), hbp: cnt_t'(p_def_hbp),
    vfp: cnt_t'(p_def_vfp), vpulse: cnt_t'(p_def_vpulse), vbp: cnt_t'(p_def_vbp),
    hpol: p_def_hpol, vpol: p_def_vpol};
  localparam cnt_t def_x_origin = cnt_t'(-(p_def_hfp + p_def_hpulse + p_def_hbp));
  localparam cnt_t def_y_origin = cnt_t'(-(p_def_vfp + p_def_vpulse + p_def_vbp));
  localparam cnt_t one = cnt_t'(1);
  localparam logic [cw+1:0] sum_lim = {3'b000, {(cw-1){1'b1}}};
  localparam logic [4:0] strb_idle = {p_def_hpol, p_def_vpol, 3'b000};

  timing_cfg_t act_cfg, pend_cfg, in_cfg;
  logic pend_vld;
  logic signed [cw-1:0] x_pos, y_pos;
  logic signed [cw-1:0] x_origin, y_origin, pend_x_origin, pend_y_origin;
  logic signed [cw-1:0] hs_start, hs_end, vs_start, vs_end, x_last, y_last;
  logic [cw+1:0] in_hsum, in_vsum;
  logic cfg_ok, xfer, x_at_last, y_at_last, at_last, in_hs, in_vs;
  logic [4:0] raw_strb;
  logic [4:0] strb_dly [p_sync_delay];

  assign in_cfg = '{width: i_cfg_width, height: i_cfg_height, hfp: i_cfg_hfp,
                    hpulse: i_cfg_hpulse, hbp: i_cfg_hbp, vfp: i_cfg_vfp,
                    vpulse: i_cfg_vpulse, vbp: i_cfg_vbp, hpol: i_cfg_hpol, vpol: i_cfg_vpol};

  // Blanking sums are checked in two extra bits so an overflowing total cannot wrap into range.
  assign in_hsum = {2'b00, i_cfg_hfp} + {2'b00, i_cfg_hpulse} + {2'b00, i_cfg_hbp};
  assign in_vsum = {2'b00, i_cfg_vfp} + {2'b00, i_cfg_vpulse} + {2'b00, i_cfg_vbp};
  assign cfg_ok  = (|i_cfg_width) && (|i_cfg_height) && (|i_cfg_hpulse) && (|i_cfg_vpulse) &&
                   !i_cfg_width[cw-1] && !i_cfg_height[cw-1] &&
                   (in_hsum <= sum_lim) && (in_vsum <= sum_lim);
  assign xfer    = i_cfg_valid && !pend_vld;

  assign x_origin      = $signed(cnt_t'(0) - act_cfg.hfp - act_cfg.hpulse - act_cfg.hbp);
  assign y_origin      = $signed(cnt_t'(0) - act_cfg.vfp - act_cfg.vpulse - act_cfg.vbp);
  assign pend_x_origin = $signed(cnt_t'(0) - pend_cfg.hfp - pend_cfg.hpulse - pend_cfg.hbp);
  assign pend_y_origin = $signed(cnt_t'(0) - pend_cfg.vfp - pend_cfg.vpulse - pend_cfg.vbp);
  assign hs_start      = x_origin + $signed(act_cfg.hfp);
  assign hs_end        = hs_start + $signed(act_cfg.hpulse);
  assign vs_start      = y_origin + $signed(act_cfg.vfp);
  assign vs_end        = vs_start + $signed(act_cfg.vpulse);
  assign x_last        = $signed(act_cfg.width - one);
  assign y_last        = $signed(act_cfg.height - one);

  assign x_at_last = (x_pos == x_last);
  assign y_at_last = (y_pos == y_last);
  assign at_last   = x_at_last && y_at_last;

  assign in_hs    = (x_pos >= hs_start) && (x_pos < hs_end);
  assign in_vs    = (y_pos >= vs_start) && (y_pos < vs_end);
  assign raw_strb = {act_cfg.hpol ^ in_hs, act_cfg.vpol ^ in_vs,
                     !x_pos[cw-1] && !y_pos[cw-1], ~|x_pos && ~|y_pos, ~|x_pos};

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      act_cfg       <= def_cfg;
      pend_cfg      <= def_cfg;
      pend_vld      <= 1'b0;
      x_pos         <= $signed(def_x_origin);
      y_pos         <= $signed(def_y_origin);
      o_cfg_applied <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      o_cfg_err     <= xfer && !cfg_ok;
      o_cfg_applied <= at_last && pend_vld;
      if (!x_at_last) begin
        x_pos <= x_pos + $signed(one);
      end else if (!y_at_last) begin
        x_pos <= x_origin;
        y_pos <= y_pos + $signed(one);
      end else if (pend_vld) begin
        act_cfg <= pend_cfg;
        x_pos   <= pend_x_origin;
        y_pos   <= pend_y_origin;
      end else begin
        x_pos <= x_origin;
        y_pos <= y_origin;
      end
      // Ready is low while pending, so a new transfer and an apply never coincide.
      if (xfer && cfg_ok) begin
        pend_cfg <= in_cfg;
        pend_vld <= 1'b1;
      end else if (at_last) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      for (int i = 0; i < p_sync_delay; i++) strb_dly[i] <= strb_idle;
    end else begin
      strb_dly[0] <= raw_strb;
      for (int i = 1; i < p_sync_delay; i++) strb_dly[i] <= strb_dly[i-1];
    end
  end

  assign {o_hsync, o_vsync, o_data_en, o_frame, o_line} = strb_dly[p_sync_delay-1];
  assign o_cfg_ready = !pend_vld;
  assign o_x_pos     = x_pos;
  assign o_y_pos     = y_pos;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: a default-mode instance (delay 1) and a small-mode instance (delay 4) checked every cycle against a frame-index model.
module tb_video_timing_gen;
  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] w, h, hfp, hp, hbp, vfp, vp, vbp;
    logic hpol, vpol;
  } cfg_in_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cv [2];
  cfg_in_t cin [2];
  logic rdy [2], app [2], err [2], hs [2], vs [2], de [2], fr [2], ln [2];
  logic signed [N-1:0] xp [2], yp [2];

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;

  video_timing_gen #(.p_count_width(N), .p_sync_delay(1)) u0 (
    .i_clk_pixel(clk), .i_rst(rst), .i_cfg_valid(cv[0]), .o_cfg_ready(rdy[0]),
    .i_cfg_width(cin[0].w), .i_cfg_height(cin[0].h), .i_cfg_hfp(cin[0].hfp),
    .i_cfg_hpulse(cin[0].hp), .i_cfg_hbp(cin[0].hbp), .i_cfg_vfp(cin[0].vfp),
    .i_cfg_vpulse(cin[0].vp), .i_cfg_vbp(cin[0].vbp), .i_cfg_hpol(cin[0].hpol),
    .i_cfg_vpol(cin[0].vpol), .o_cfg_applied(app[0]), .o_cfg_err(err[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_data_en(de[0]), .o_frame(fr[0]),
    .o_line(ln[0]), .o_x_pos(xp[0]), .o_y_pos(yp[0]));

  video_timing_gen #(.p_count_width(N), .p_sync_delay(4),
    .p_def_width(6), .p_def_height(3), .p_def_hfp(2), .p_def_hpulse(2), .p_def_hbp(1),
    .p_def_vfp(1), .p_def_vpulse(1), .p_def_vbp(2), .p_def_hpol(1'b0), .p_def_vpol(1'b1)) u1 (
    .i_clk_pixel(clk), .i_rst(rst), .i_cfg_valid(cv[1]), .o_cfg_ready(rdy[1]),
    .i_cfg_width(cin[1].w), .i_cfg_height(cin[1].h), .i_cfg_hfp(cin[1].hfp),
    .i_cfg_hpulse(cin[1].hp), .i_cfg_hbp(cin[1].hbp), .i_cfg_vfp(cin[1].vfp),
    .i_cfg_vpulse(cin[1].vp), .i_cfg_vbp(cin[1].vbp), .i_cfg_hpol(cin[1].hpol),
    .i_cfg_vpol(cin[1].vpol), .o_cfg_applied(app[1]), .o_cfg_err(err[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_data_en(de[1]), .o_frame(fr[1]),
    .o_line(ln[1]), .o_x_pos(xp[1]), .o_y_pos(yp[1]));

  // ---------------- reference model ----------------
  function automatic int dly(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic cfg_in_t def_cfg(int k);
    cfg_in_t c;
    if (k == 0) c = '{w:16'd640, h:16'd480, hfp:16'd16, hp:16'd96, hbp:16'd48,
                      vfp:16'd10, vp:16'd2, vbp:16'd33, hpol:1'b1, vpol:1'b1};
    else        c = '{w:16'd6, h:16'd3, hfp:16'd2, hp:16'd2, hbp:16'd1,
                      vfp:16'd1, vp:16'd1, vbp:16'd2, hpol:1'b0, vpol:1'b1};
    return c;
  endfunction

  function automatic int hblank(cfg_in_t c);
    return int'(c.hfp) + int'(c.hp) + int'(c.hbp);
  endfunction
  function automatic int vblank(cfg_in_t c);
    return int'(c.vfp) + int'(c.vp) + int'(c.vbp);
  endfunction
  function automatic int htot(cfg_in_t c);
    return int'(c.w) + hblank(c);
  endfunction
  function automatic int ftot(cfg_in_t c);
    return htot(c) * (int'(c.h) + vblank(c));
  endfunction

  function automatic bit cfg_ok(cfg_in_t c);
    int lim;
    lim = 2 ** (N - 1) - 1;
    return c.w >= 1 && c.h >= 1 && c.hp >= 1 && c.vp >= 1 && int'(c.w) <= lim &&
           int'(c.h) <= lim && hblank(c) <= lim && vblank(c) <= lim;
  endfunction

  // Position of frame cycle t: row-major walk starting at the blanking origin.
  function automatic int px(cfg_in_t c, int t);
    return -hblank(c) + t % htot(c);
  endfunction
  function automatic int py(cfg_in_t c, int t);
    return -vblank(c) + t / htot(c);
  endfunction

  function automatic logic [4:0] raw(cfg_in_t c, int t);
    int x, y, hst, vst;
    bit hin, vin;
    x   = px(c, t);
    y   = py(c, t);
    hst = -hblank(c) + int'(c.hfp);
    vst = -vblank(c) + int'(c.vfp);
    hin = (x >= hst) && (x < hst + int'(c.hp));
    vin = (y >= vst) && (y < vst + int'(c.vp));
    return {c.hpol ^ hin, c.vpol ^ vin, x >= 0 && y >= 0, x == 0 && y == 0, x == 0};
  endfunction

  cfg_in_t m_cfg [2], m_pcfg [2];
  bit m_pend [2], m_err [2], m_app [2];
  int m_t [2], m_cyc [2];
  logic [4:0] m_hist [2][16];
  bit started = 1'b0;

  always @(posedge clk) begin : model
    bit xfer, ok, last;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cfg[k] = def_cfg(k);
        m_pend[k] = 1'b0; m_err[k] = 1'b0; m_app[k] = 1'b0;
        m_t[k] = 0; m_cyc[k] = 0;
      end else if (started) begin
        xfer = cv[k] && !m_pend[k];
        ok   = cfg_ok(cin[k]);
        last = (m_t[k] == ftot(m_cfg[k]) - 1);
        m_err[k] = xfer && !ok;
        m_app[k] = last && m_pend[k];
        if (last) begin
          m_t[k] = 0;
          if (m_pend[k]) begin
            m_cfg[k] = m_pcfg[k];
            m_pend[k] = 1'b0;
          end
        end else begin
          m_t[k]++;
        end
        if (xfer && ok) begin
          m_pend[k] = 1'b1;
          m_pcfg[k] = cin[k];
        end
        m_cyc[k]++;
      end
      m_hist[k][m_cyc[k] % 16] = raw(m_cfg[k], m_t[k]);
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [4:0] es, gs;
    int ex, ey;
    cfg_in_t d;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        d  = def_cfg(k);
        es = (m_cyc[k] >= dly(k)) ? m_hist[k][(m_cyc[k] - dly(k)) % 16] : {d.hpol, d.vpol, 3'b000};
        ex = px(m_cfg[k], m_t[k]);
        ey = py(m_cfg[k], m_t[k]);
        gs = {hs[k], vs[k], de[k], fr[k], ln[k]};
        vectors++;
        if (int'(xp[k]) != ex || int'(yp[k]) != ey || gs !== es || rdy[k] !== !m_pend[k] ||
            app[k] !== m_app[k] || err[k] !== m_err[k]) begin
          miscompares++;
          if (nprint < 20) begin
            nprint++;
            $display("FAIL model[%0d] t=%0t: got x=%0d y=%0d strb=%b rdy=%b app=%b err=%b, want x=%0d y=%0d strb=%b rdy=%b app=%b err=%b",
                     k, $time, xp[k], yp[k], gs, rdy[k], app[k], err[k], ex, ey, es, !m_pend[k], m_app[k], m_err[k]);
          end
        end
      end
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic timeout(string name);
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic cfg_in_t mk(int w, int h, int hfp, int hp, int hbp, int vfp, int vp, int vbp, bit hpol, bit vpol);
    cfg_in_t c;
    c = '{w:N'(w), h:N'(h), hfp:N'(hfp), hp:N'(hp), hbp:N'(hbp), vfp:N'(vfp), vp:N'(vp), vbp:N'(vbp), hpol:hpol, vpol:vpol};
    return c;
  endfunction

  function automatic cfg_in_t rand_cfg();
    cfg_in_t c;
    c = mk($urandom_range(0, 8), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 2),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    case ($urandom_range(0, 15))
      0: c.w = 16'h8000;
      1: begin c.hfp = 16'h7FFE; c.hp = 16'd1; c.hbp = 16'd1; end
      2: c.vbp = 16'hFFFF;
      3: c.h = 16'h8000;
      default: ;
    endcase
    return c;
  endfunction

  initial begin
    int c;
    bit seen;
    cv[0] = 1'b0; cv[1] = 1'b0;
    cin[0] = def_cfg(0); cin[1] = def_cfg(1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x0", xp[0], -160);
    check("rst_y0", yp[0], -45);
    check("rst_hs0", hs[0], 1);
    check("rst_vs0", vs[0], 1);
    check("rst_de0", de[0], 0);
    check("rst_rdy0", rdy[0], 1);
    check("rst_x1", xp[1], -5);
    check("rst_y1", yp[1], -4);
    check("rst_hs1", hs[1], 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_inc_x0", xp[0], -159);

    // Default mode: hsync window on the first line, plus an invalid and a valid offer.
    for (int i = 0; i < 900; i++) begin
      if (yp[0] == -16'sd45) begin
        case (int'(xp[0]))
          -144: check("hs_before_pulse", hs[0], 1);
          -143: check("hs_pulse_start", hs[0], 0);
          -48:  check("hs_pulse_last", hs[0], 0);
          -47:  check("hs_after_pulse", hs[0], 1);
          default: ;
        endcase
      end
      if (i == 101) begin
        check("err_pulse", err[0], 1);
        check("err_rdy", rdy[0], 1);
      end
      if (i == 301) check("pend_rdy_low", rdy[0], 0);
      cv[0] = (i == 100) || (i == 300);
      cin[0] = (i == 100) ? mk(0, 480, 16, 96, 48, 10, 2, 33, 1, 1) : mk(4, 2, 1, 1, 1, 1, 1, 1, 0, 0);
      @(negedge clk);
    end
    cv[0] = 1'b0;

    // Strobe lag of four cycles behind the first visible pixel of a line.
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (xp[1] == 0 && yp[1] >= 0) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("de_lag_wait");
    repeat (3) @(negedge clk);
    check("de_lag3", de[1], 0);
    @(negedge clk);
    check("de_lag4", de[1], 1);
    check("line_lag4", ln[1], 1);

    // Mid-frame load of the 4x2 mode.
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (xp[1] == 1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("mid_wait");
    cv[1] = 1'b1; cin[1] = mk(4, 2, 1, 1, 1, 1, 1, 1, 0, 0);
    @(negedge clk);
    cv[1] = 1'b0;
    check("mid_rdy_low", rdy[1], 0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (app[1]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("mid_apply_wait");
    check("apply_x", xp[1], -3);
    check("apply_y", yp[1], -3);
    check("apply_rdy", rdy[1], 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (fr[1]) seen = 1'b1;
    end
    if (!seen) timeout("frame_wait");
    c = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      c++;
      if (fr[1]) seen = 1'b1;
    end
    if (!seen) timeout("frame_period_wait");
    check("frame_period", c, 35);

    // Offer on the last pixel: old mode runs one more full frame.
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (xp[1] == 3 && yp[1] == 1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("last_pixel_wait");
    cv[1] = 1'b1; cin[1] = mk(5, 2, 1, 2, 1, 1, 1, 1, 1, 0);
    c = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cv[1] = 1'b0;
      c++;
      if (c == 1) check("last_px_rdy", rdy[1], 0);
      if (app[1]) seen = 1'b1;
    end
    if (!seen) timeout("last_px_apply_wait");
    check("last_px_apply_delay", c, 36);

    // Randomized offers, illegal boundaries and occasional resets.
    for (int i = 0; i < 15000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      cv[1] = ($urandom_range(0, 7) == 0);
      cin[1] = rand_cfg();
      @(negedge clk);
    end
    rst = 1'b0; cv[1] = 1'b0;

    // Reset while a config is pending.
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (rdy[1]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("rdy_wait");
    cv[1] = 1'b1; cin[1] = mk(3, 3, 1, 1, 1, 1, 1, 1, 1, 1);
    @(negedge clk);
    cv[1] = 1'b0;
    check("pend_before_rst", rdy[1], 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pend_rdy", rdy[1], 1);
    check("rst_pend_x", xp[1], -5);
    check("rst_pend_y", yp[1], -4);
    check("rst_pend_de", de[1], 0);
    check("rst_pend_hs", hs[1], 0);
    check("rst_pend_x0", xp[0], -160);
    check("rst_pend_y0", yp[0], -45);
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
